vertex_mem_ctrl: RTL

VERTEX_MEM_CTRL -- requirements
Module: vertex_mem_ctrl

---
 rtl/vertex_pkg.sv | 34 +++
 rtl/vertex_mem_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vertex_pkg.sv
// Shared types and constants for the vertex memory controller: vertex layout,
// controller state encoding and the word selector used when streaming a vertex.
package vertex_pkg;

  localparam int NUM_VERTS = 682;
  localparam int ADDR_W    = 11;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] y;
    logic [31:0] x;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD       = 3'd2,
    RD_DRAIN = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Word k of a vertex in RAM order (0 = x, 1 = y, 2 = z).
  function automatic logic [31:0] vertex_word(input vertex_t v, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = v.x;
      2'd1:    w = v.y;
      2'd2:    w = v.z;
      default: w = 32'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/vertex_mem_ctrl.sv
// Vertex store/fetch controller: maps one 96-bit vertex onto three consecutive
// 32-bit words of a quad RAM, with an error response for out-of-range indices.
module vertex_mem_ctrl #(
  parameter int NUM_VERTS = vertex_pkg::NUM_VERTS,
  parameter int ADDR_W    = vertex_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [9:0]        req_index,
  input  logic [95:0]       req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [95:0]       resp_data,
  output logic              resp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  import vertex_pkg::*;

  state_t              state_r;
  logic [1:0]          k_r;
  logic [ADDR_W-1:0]   base_r;
  vertex_t             wdata_r;
  vertex_t             rdata_r;
  logic                req_ready_r;
  logic                resp_valid_r;
  logic                resp_err_r;
  logic                mem_en_r;
  logic [3:0]          mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [31:0]         mem_din_r;

  logic                hs_s;
  logic                idx_bad_s;
  logic [ADDR_W-1:0]   base_s;
  logic [1:0]          k_next_s;
  logic [ADDR_W-1:0]   addr_next_s;

  assign hs_s        = req_valid & req_ready_r;
  assign idx_bad_s   = (32'(req_index) >= 32'(NUM_VERTS));
  // index*3 as a shift-and-add, kept in ADDR_W bits; the top slot still fits without wrapping
  assign base_s      = ADDR_W'({req_index, 1'b0}) + ADDR_W'(req_index);
  assign k_next_s    = k_r + 2'd1;
  assign addr_next_s = base_r + ADDR_W'(k_next_s);

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = mem_din_r;

  // Controller FSM with registered RAM strobes and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      k_r          <= 2'd0;
      base_r       <= '0;
      wdata_r      <= '0;
      rdata_r      <= '0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 4'b0000;
      mem_addr_r   <= '0;
      mem_din_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            req_ready_r <= 1'b0;
            k_r         <= 2'd0;
            base_r      <= base_s;
            wdata_r     <= req_data;
            rdata_r     <= '0;
            resp_err_r  <= idx_bad_s;
            if (idx_bad_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
            end else if (req_write) begin
              state_r    <= WR;
              mem_en_r   <= 1'b1;
              mem_we_r   <= 4'b1111;
              mem_addr_r <= base_s;
              mem_din_r  <= vertex_word(req_data, 2'd0);
            end else begin
              state_r    <= RD;
              mem_en_r   <= 1'b1;
              mem_we_r   <= 4'b0000;
              mem_addr_r <= base_s;
              mem_din_r  <= 32'd0;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        WR: begin
          if (k_r == 2'd2) begin
            state_r      <= RESP;
            k_r          <= 2'd0;
            resp_valid_r <= 1'b1;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 4'b0000;
            mem_addr_r   <= '0;
            mem_din_r    <= 32'd0;
          end else begin
            k_r        <= k_next_s;
            mem_addr_r <= addr_next_s;
            mem_din_r  <= vertex_word(wdata_r, k_next_s);
          end
        end
        RD: begin
          // RAM data lags the address by one cycle, so word k-1 lands while word k is addressed
          case (k_r)
            2'd1:    rdata_r.x <= mem_dout;
            2'd2:    rdata_r.y <= mem_dout;
            default: rdata_r   <= rdata_r;
          endcase
          if (k_r == 2'd2) begin
            state_r    <= RD_DRAIN;
            k_r        <= 2'd0;
            mem_en_r   <= 1'b0;
            mem_addr_r <= '0;
          end else begin
            k_r        <= k_next_s;
            mem_addr_r <= addr_next_s;
          end
        end
        RD_DRAIN: begin
          rdata_r.z    <= mem_dout;
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            rdata_r      <= '0;
            req_ready_r  <= 1'b1;
          end else begin
            resp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          k_r          <= 2'd0;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          mem_en_r     <= 1'b0;
          mem_we_r     <= 4'b0000;
          mem_addr_r   <= '0;
          mem_din_r    <= 32'd0;
        end
      endcase
    end
  end

endmodule
